// File: rtl/ttl_counter_mod_pkg.sv
// Shared counter definitions: up_n direction encoding and the next-count function
// used by the counter RTL.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Values at or above the terminal count wrap to 0 when counting up. Counting
  // down from such a value decrements normally, so an out-of-range load drains
  // back into range.
  function automatic logic [31:0] cnt_next(input logic [31:0]       q,
                                           input logic              dir_up,
                                           input longint unsigned   modulus,
                                           input int unsigned       width);
    logic [63:0] mask;
    logic [63:0] qq;
    logic [63:0] r;
    mask = (64'd1 << width) - 64'd1;
    qq   = {32'd0, q} & mask;
    if (dir_up) begin
      r = (qq >= modulus - 64'd1) ? 64'd0 : qq + 64'd1;
    end else begin
      r = (qq == 64'd0) ? modulus - 64'd1 : qq - 64'd1;
    end
    return 32'(r & mask);
  endfunction

endpackage

// File: rtl/ttl_counter_mod_if.sv
// Control/data bundle of one counter stage; master drives the controls, slave is the counter.
interface ttl_counter_mod_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clr_n;
  logic             load;
  logic             enp;
  logic             ent;
  logic             up_n;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (output clr_n, load, enp, ent, up_n, d,
                  input  q, tc, wrap);
  modport slave  (input  clr_n, load, enp, ent, up_n, d,
                  output q, tc, wrap);
endinterface

// File: rtl/ttl_counter_mod.sv
// Presettable up/down modulo counter with '161-style ENP/ENT/TC cascade chain
// and a registered wrap pulse. Priority per edge: clear, load, count, hold.
module ttl_counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  parameter bit              UPDOWN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  ttl_counter_mod_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "ttl_counter_mod: WIDTH %0d outside 1..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "ttl_counter_mod: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             dir_up;
  logic             at_term_up;
  logic             at_term_dn;

  assign dir_up     = !UPDOWN || (bus.up_n == DIR_UP);
  assign at_term_up = (q_q >= TERM);
  assign at_term_dn = (q_q == '0);

  // A clear or load on the terminal edge replaces the count, so no wrap pulse.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!bus.clr_n) begin
      q_d = '0;
    end else if (bus.load) begin
      q_d = bus.d;
    end else if (bus.enp && bus.ent) begin
      q_d    = WIDTH'(cnt_next(32'(q_q), dir_up, MODULUS, WIDTH));
      wrap_d = dir_up ? at_term_up : at_term_dn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = bus.ent && (dir_up ? at_term_up : at_term_dn);

endmodule

// File: tb/tb_ttl_counter_mod.sv
// Scoreboarded bench: a decade up/down counter plus a two-stage 8-bit cascade.
module tb_ttl_counter_mod;
  import counter_pkg::*;

  typedef struct {
    bit         sel;   // 0 = decade counter, 1 = cascade
    logic [7:0] q;
    logic       wrap;
    logic       tc;
    string      nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cas_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ttl_counter_mod_if #(.WIDTH(4)) dec_if ();
  ttl_counter_mod_if #(.WIDTH(4)) lo_if ();
  ttl_counter_mod_if #(.WIDTH(4)) hi_if ();

  ttl_counter_mod #(.WIDTH(4), .MODULUS(10), .UPDOWN(1'b1)) u_dec (
    .clk(clk), .rst_n(rst_n), .bus(dec_if.slave));

  // cascade_tb_top: low tc feeds high ent, common enp.
  ttl_counter_mod #(.WIDTH(4), .MODULUS(16), .UPDOWN(1'b1)) u_cas_lo (
    .clk(clk), .rst_n(rst_n), .bus(lo_if.slave));
  ttl_counter_mod #(.WIDTH(4), .MODULUS(16), .UPDOWN(1'b1)) u_cas_hi (
    .clk(clk), .rst_n(rst_n), .bus(hi_if.slave));

  assign lo_if.ent = 1'b1;
  assign hi_if.ent = lo_if.tc;
  assign lo_if.enp = cas_en;
  assign hi_if.enp = cas_en;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic push(input bit sel, input logic [7:0] q, input logic w, input logic t,
                      input string nm);
    exp_t e;
    e.sel = sel; e.q = q; e.wrap = w; e.tc = t; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic c, input logic l, input logic p, input logic t,
                      input logic u, input logic [3:0] dd, input logic [3:0] eq,
                      input logic ew, input logic et, input string nm);
    @(negedge clk);
    dec_if.clr_n = c; dec_if.load = l; dec_if.enp = p; dec_if.ent = t;
    dec_if.up_n = u; dec_if.d = dd;
    push(1'b0, {4'd0, eq}, ew, et, nm);
  endtask

  // Assert reset mid-cycle, check it acts without a clock edge, then release
  // with counting enabled so the first edge after release gives q=1.
  task automatic mid_reset(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({nm, "_q"}, 32'(dec_if.q), 32'd0);
    chk({nm, "_wrap"}, 32'(dec_if.wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b0, 8'd1, 1'b0, 1'b0, {nm, "_first"});
  endtask

  // Monitor: compare the scoreboard head against the DUT just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel == 1'b0) begin
          chk({e.nm, "_q"}, 32'(dec_if.q), 32'(e.q));
          chk({e.nm, "_wrap"}, 32'(dec_if.wrap), 32'(e.wrap));
          chk({e.nm, "_tc"}, 32'(dec_if.tc), 32'(e.tc));
        end else begin
          chk({e.nm, "_q"}, 32'({hi_if.q, lo_if.q}), 32'(e.q));
          chk({e.nm, "_wrap"}, 32'(hi_if.wrap), 32'(e.wrap));
          chk({e.nm, "_tc"}, 32'(hi_if.tc), 32'(e.tc));
        end
      end
    end
  end

  initial begin
    dec_if.clr_n = 1'b1; dec_if.load = 1'b0; dec_if.enp = 1'b0; dec_if.ent = 1'b0;
    dec_if.up_n = DIR_UP; dec_if.d = 4'd0;
    lo_if.clr_n = 1'b1; lo_if.load = 1'b0; lo_if.up_n = DIR_UP; lo_if.d = 4'd0;
    hi_if.clr_n = 1'b1; hi_if.load = 1'b0; hi_if.up_n = DIR_UP; hi_if.d = 4'd0;
    #12;
    chk("rst_q", 32'(dec_if.q), 32'd0);
    chk("rst_wrap", 32'(dec_if.wrap), 32'd0);
    chk("rst_tc", 32'(dec_if.tc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while counting at 7.
    step(1, 1, 0, 1, DIR_UP, 4'd5, 4'd5, 0, 0, "ld5");
    step(1, 0, 1, 1, DIR_UP, 4'd0, 4'd6, 0, 0, "cnt6");
    step(1, 0, 1, 1, DIR_UP, 4'd0, 4'd7, 0, 0, "cnt7");
    mid_reset("rst_mid");

    // Decade count up from 0.
    step(0, 0, 1, 1, DIR_UP, 4'd0, 4'd0, 0, 0, "clr");
    for (int i = 1; i <= 11; i++) begin
      step(1, 0, 1, 1, DIR_UP, 4'd0, 4'(i % 10), (i % 10) == 0, (i % 10) == 9,
           $sformatf("up%0d", i));
    end

    // Down counting and direction flip.
    step(1, 1, 1, 1, DIR_UP,   4'd2, 4'd2, 0, 0, "ld2");
    step(1, 0, 1, 1, DIR_DOWN, 4'd0, 4'd1, 0, 0, "dn1");
    step(1, 0, 1, 1, DIR_DOWN, 4'd0, 4'd0, 0, 1, "dn0");
    step(1, 0, 1, 1, DIR_DOWN, 4'd0, 4'd9, 1, 0, "dn9");
    @(negedge clk);
    dec_if.up_n = DIR_UP;
    #1 chk("flip_tc", 32'(dec_if.tc), 32'd1);
    push(1'b0, 8'd0, 1'b1, 1'b0, "flip_next");

    // Priority: load over count, clear over load, enp gating.
    step(1, 1, 1, 1, DIR_UP, 4'd9, 4'd9, 0, 1, "ld9a");
    step(1, 1, 1, 1, DIR_UP, 4'd5, 4'd5, 0, 0, "ld_over_cnt");
    step(1, 1, 1, 1, DIR_UP, 4'd9, 4'd9, 0, 1, "ld9b");
    step(0, 1, 1, 1, DIR_UP, 4'd3, 4'd0, 0, 0, "clr_over_ld");
    step(1, 1, 1, 1, DIR_UP, 4'd9, 4'd9, 0, 1, "ld9c");
    step(1, 0, 0, 1, DIR_UP, 4'd0, 4'd9, 0, 1, "hold_a");
    step(1, 0, 0, 1, DIR_UP, 4'd0, 4'd9, 0, 1, "hold_b");

    // Out-of-range loads.
    step(1, 1, 1, 1, DIR_UP,   4'd12, 4'd12, 0, 1, "ld12u");
    step(1, 0, 1, 1, DIR_UP,   4'd0,  4'd0,  1, 0, "oor_up");
    step(1, 1, 1, 1, DIR_DOWN, 4'd12, 4'd12, 0, 0, "ld12d");
    step(1, 0, 1, 1, DIR_DOWN, 4'd0,  4'd11, 0, 0, "oor_dn11");
    step(1, 0, 1, 1, DIR_DOWN, 4'd0,  4'd10, 0, 0, "oor_dn10");

    // Reset while a wrap pulse is showing.
    step(1, 1, 1, 1, DIR_UP, 4'd9, 4'd9, 0, 1, "ld9d");
    step(1, 0, 1, 1, DIR_UP, 4'd0, 4'd0, 1, 0, "wrap_pre_rst");
    mid_reset("rst_wrap");

    // Cascade: 512 edges covers two high-stage wraps.
    @(negedge clk);
    dec_if.enp = 1'b0;
    cas_en = 1'b1;
    push(1'b1, 8'd1, 1'b0, 1'b0, "cas1");
    for (int i = 2; i <= 512; i++) begin
      @(negedge clk);
      push(1'b1, 8'(i), 8'(i) == 8'd0, 8'(i) == 8'hFF, $sformatf("cas%0d", i));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
